// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS datapath. It sequences ALU, memory, IR, PC and
// register-file strobes and stretches memory states until the memory reports ready.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic [3:0] ula_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_instr,
    output logic       instr_done
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRA  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_LUI  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_SLLV = 4'b1110;
    localparam logic [3:0] OP_VSH  = 4'b1111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] op_reg;
    logic       ext_zero_reg;
    logic       store_reg;
    logic       bne_reg;

    state_t     dec_next;
    logic [3:0] dec_op;
    logic       dec_ext_zero;
    logic       dec_legal;

    // Instruction decode; only consumed in DECODE, where the IR has just been loaded.
    always_comb begin
        dec_next     = FETCH;
        dec_op       = OP_AND;
        dec_ext_zero = 1'b0;
        dec_legal    = 1'b1;
        case (opcode)
            6'h23, 6'h2B: dec_next = MEM_ADDR;
            6'h00: begin
                dec_next = R_EXEC;
                case (funct)
                    6'h20, 6'h21: dec_op = OP_ADD;
                    6'h22, 6'h23: dec_op = OP_SUB;
                    6'h24:        dec_op = OP_AND;
                    6'h25:        dec_op = OP_OR;
                    6'h26:        dec_op = OP_XOR;
                    6'h27:        dec_op = OP_NOR;
                    6'h2A:        dec_op = OP_SLT;
                    6'h00:        dec_op = OP_SLL;
                    6'h02:        dec_op = OP_SRL;
                    6'h03:        dec_op = OP_SRA;
                    6'h04:        dec_op = OP_SLLV;
                    6'h06, 6'h07: dec_op = OP_VSH;
                    default:      dec_legal = 1'b0;
                endcase
            end
            6'h04, 6'h05: dec_next = BRANCH;
            6'h02:        dec_next = JUMP;
            6'h08, 6'h09: begin dec_next = I_EXEC; dec_op = OP_ADD; end
            6'h0A:        begin dec_next = I_EXEC; dec_op = OP_SLT; end
            6'h0C:        begin dec_next = I_EXEC; dec_op = OP_AND; dec_ext_zero = 1'b1; end
            6'h0D:        begin dec_next = I_EXEC; dec_op = OP_OR;  dec_ext_zero = 1'b1; end
            6'h0E:        begin dec_next = I_EXEC; dec_op = OP_XOR; dec_ext_zero = 1'b1; end
            6'h0F:        begin dec_next = I_EXEC; dec_op = OP_LUI; end
            default:      dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_next = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= FETCH;
            op_reg       <= OP_AND;
            ext_zero_reg <= 1'b0;
            store_reg    <= 1'b0;
            bne_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                op_reg       <= dec_op;
                ext_zero_reg <= dec_ext_zero;
                store_reg    <= (opcode == 6'h2B);
                bne_reg      <= (opcode == 6'h05);
            end
        end
    end

    // Outputs are forced low while reset is asserted so no write strobe leaks into that cycle.
    always_comb begin
        state_next    = state_reg;
        ula_op        = OP_AND;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ext_zero      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_source     = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_instr = 1'b0;
        instr_done    = 1'b0;
        if (rst_n) begin
            case (state_reg)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ula_op    = OP_ADD;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b     = 2'b11;
                    ula_op        = OP_ADD;
                    illegal_instr = ~dec_legal;
                    state_next    = dec_next;
                end
                MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    ula_op     = OP_ADD;
                    state_next = store_reg ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        state_next = MEM_WB;
                    end
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end
                end
                R_EXEC: begin
                    alu_src_a  = 1'b1;
                    ula_op     = op_reg;
                    state_next = R_WB;
                end
                R_WB: begin
                    ula_op     = op_reg;
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    ula_op     = OP_SUB;
                    pc_source  = 2'b01;
                    pc_write   = bne_reg ? ~zero_flag : zero_flag;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                I_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    ula_op     = op_reg;
                    ext_zero   = ext_zero_reg;
                    state_next = I_WB;
                end
                I_WB: begin
                    ula_op     = op_reg;
                    ext_zero   = ext_zero_reg;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-instruction model builds the expected cycle-by-cycle
// strobe sequence (with memory wait states) and each test compares the DUT against it.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero_flag, mem_ready;
    logic [3:0] ula_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero, mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_source;
    logic       reg_write, reg_dst, mem_to_reg, illegal_instr, instr_done;

    typedef struct packed {
        logic [3:0] ula_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_instr;
        logic       instr_done;
    } outs_t;

    typedef struct packed {
        logic  ready;
        outs_t o;
    } step_t;

    outs_t cur;
    step_t exp_q[$];
    outs_t obs_q[$];
    int    errors = 0;
    int    checks = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero_flag(zero_flag), .mem_ready(mem_ready), .ula_op(ula_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal_instr(illegal_instr), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    assign cur = {ula_op, alu_src_a, alu_src_b, ext_zero, mem_read, mem_write, i_or_d,
                  ir_write, pc_write, pc_source, reg_write, reg_dst, mem_to_reg,
                  illegal_instr, instr_done};

    task automatic push(input logic rdy, input outs_t o);
        step_t s;
        s.ready = rdy;
        s.o     = o;
        exp_q.push_back(s);
    endtask

    // Expected sequence for one instruction: fw FETCH waits, mw data-memory waits.
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
        outs_t f;
        int    cls;
        logic [3:0] aop;
        logic  ez;
        exp_q.delete();
        f = '0; f.mem_read = 1'b1; f.alu_src_b = 2'b01; f.ula_op = 4'b0010;
        for (int i = 0; i < fw; i++) push(1'b0, f);
        f.ir_write = 1'b1; f.pc_write = 1'b1;
        push(1'b1, f);
        cls = 0; aop = 4'b0000; ez = 1'b0;
        case (op)
            6'h23: cls = 1;
            6'h2B: cls = 2;
            6'h04: cls = 4;
            6'h05: cls = 5;
            6'h02: cls = 6;
            6'h08, 6'h09: begin cls = 7; aop = 4'b0010; end
            6'h0A: begin cls = 7; aop = 4'b0111; end
            6'h0C: begin cls = 7; aop = 4'b0000; ez = 1'b1; end
            6'h0D: begin cls = 7; aop = 4'b0001; ez = 1'b1; end
            6'h0E: begin cls = 7; aop = 4'b1101; ez = 1'b1; end
            6'h0F: begin cls = 7; aop = 4'b1011; end
            6'h00: begin
                cls = 3;
                case (fn)
                    6'h20, 6'h21: aop = 4'b0010;
                    6'h22, 6'h23: aop = 4'b0110;
                    6'h24: aop = 4'b0000;
                    6'h25: aop = 4'b0001;
                    6'h26: aop = 4'b1101;
                    6'h27: aop = 4'b1100;
                    6'h2A: aop = 4'b0111;
                    6'h00: aop = 4'b0011;
                    6'h02: aop = 4'b0101;
                    6'h03: aop = 4'b0100;
                    6'h04: aop = 4'b1110;
                    6'h06, 6'h07: aop = 4'b1111;
                    default: cls = 0;
                endcase
            end
            default: cls = 0;
        endcase
        f = '0; f.alu_src_b = 2'b11; f.ula_op = 4'b0010;
        f.illegal_instr = (cls == 0);
        push(1'($urandom_range(0, 1)), f);
        if (cls == 1 || cls == 2) begin
            f = '0; f.alu_src_a = 1'b1; f.alu_src_b = 2'b10; f.ula_op = 4'b0010;
            push(1'($urandom_range(0, 1)), f);
            f = '0; f.i_or_d = 1'b1;
            if (cls == 1) f.mem_read = 1'b1; else f.mem_write = 1'b1;
            for (int i = 0; i < mw; i++) push(1'b0, f);
            if (cls == 2) f.instr_done = 1'b1;
            push(1'b1, f);
            if (cls == 1) begin
                f = '0; f.reg_write = 1'b1; f.mem_to_reg = 1'b1; f.instr_done = 1'b1;
                push(1'($urandom_range(0, 1)), f);
            end
        end else if (cls == 3 || cls == 7) begin
            f = '0; f.alu_src_a = 1'b1; f.ula_op = aop; f.ext_zero = ez;
            if (cls == 7) f.alu_src_b = 2'b10;
            push(1'($urandom_range(0, 1)), f);
            f = '0; f.ula_op = aop; f.ext_zero = ez; f.reg_write = 1'b1;
            f.reg_dst = (cls == 3); f.instr_done = 1'b1;
            push(1'($urandom_range(0, 1)), f);
        end else if (cls == 4 || cls == 5) begin
            f = '0; f.alu_src_a = 1'b1; f.ula_op = 4'b0110; f.pc_source = 2'b01;
            f.pc_write = (cls == 4) ? z : ~z; f.instr_done = 1'b1;
            push(1'($urandom_range(0, 1)), f);
        end else if (cls == 6) begin
            f = '0; f.pc_write = 1'b1; f.pc_source = 2'b10; f.instr_done = 1'b1;
            push(1'($urandom_range(0, 1)), f);
        end
    endtask

    // Drive the first n modelled cycles of an instruction and record DUT outputs.
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b1; opcode = op; funct = fn; zero_flag = z;
            mem_ready = exp_q[i].ready;
            #1;
            obs_q.push_back(cur);
        end
        $display("instr op=%h funct=%h zero=%0d cycles=%0d", op, fn, z, n);
    endtask

    task automatic test_reset;
        repeat (2) begin
            @(negedge clk);
            rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h23; funct = 6'h20;
            #1;
            checks++;
            if (cur !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0", cur);
            end
        end
    endtask

    task automatic test_add;
        model(6'h00, 6'h20, 1'b0, 0, 0);
        drive(6'h00, 6'h20, 1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i].o) begin
                errors++;
                $display("FAIL add cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i].o);
            end
        end
        checks++;
        if (obs_q[3].instr_done !== 1'b1 || obs_q[2].ula_op !== 4'b0010) begin
            errors++;
            $display("FAIL add_latency: done4=%b exec_op=%b expected 1/0010",
                     obs_q[3].instr_done, obs_q[2].ula_op);
        end
    endtask

    task automatic test_lw_wait;
        int nrd;
        model(6'h23, 6'h00, 1'b0, 0, 2);
        drive(6'h23, 6'h00, 1'b0, exp_q.size());
        nrd = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i].o) begin
                errors++;
                $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i].o);
            end
            if (obs_q[i].mem_read && obs_q[i].i_or_d) nrd++;
        end
        checks++;
        if (nrd !== 3 || obs_q[6].mem_to_reg !== 1'b1 || obs_q[6].instr_done !== 1'b1) begin
            errors++;
            $display("FAIL lw_hold: mem_read cycles=%0d (need 3) c7 mem_to_reg=%b done=%b",
                     nrd, obs_q[6].mem_to_reg, obs_q[6].instr_done);
        end
    endtask

    task automatic test_branch;
        model(6'h04, 6'h00, 1'b1, 0, 0);
        drive(6'h04, 6'h00, 1'b1, exp_q.size());
        checks++;
        if (obs_q[2].pc_write !== 1'b1 || obs_q[2].pc_source !== 2'b01 || obs_q[2].instr_done !== 1'b1) begin
            errors++;
            $display("FAIL beq_taken: pc_write=%b pc_source=%b done=%b expected 1/01/1",
                     obs_q[2].pc_write, obs_q[2].pc_source, obs_q[2].instr_done);
        end
        model(6'h05, 6'h00, 1'b1, 0, 0);
        drive(6'h05, 6'h00, 1'b1, exp_q.size());
        checks++;
        if (obs_q[2].pc_write !== 1'b0 || obs_q[2].instr_done !== 1'b1) begin
            errors++;
            $display("FAIL bne_not_taken: pc_write=%b done=%b expected 0/1",
                     obs_q[2].pc_write, obs_q[2].instr_done);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i].o) begin
                errors++;
                $display("FAIL bne cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i].o);
            end
        end
    endtask

    task automatic test_imm_ops;
        logic [5:0] ops [3] = '{6'h0D, 6'h0F, 6'h00};
        logic [5:0] fns [3] = '{6'h00, 6'h00, 6'h07};
        for (int k = 0; k < 3; k++) begin
            model(ops[k], fns[k], 1'b0, 1, 0);
            drive(ops[k], fns[k], 1'b0, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i].o) begin
                    errors++;
                    $display("FAIL imm_op%0d cycle %0d: got %h expected %h",
                             k, i, obs_q[i], exp_q[i].o);
                end
            end
        end
        checks++;
        if (obs_q[3].ula_op !== 4'b1111) begin
            errors++;
            $display("FAIL srav_op: got %b expected 1111", obs_q[3].ula_op);
        end
    endtask

    task automatic test_illegal;
        model(6'h3F, 6'h00, 1'b0, 0, 0);
        drive(6'h3F, 6'h00, 1'b0, exp_q.size() + 1);
        checks++;
        if (obs_q[1].illegal_instr !== 1'b1 || obs_q[1].reg_write !== 1'b0 ||
            obs_q[2].mem_read !== 1'b1 || obs_q[2].alu_src_b !== 2'b01) begin
            errors++;
            $display("FAIL illegal: pulse=%b reg_write=%b next mem_read=%b src_b=%b expected 1/0/1/01",
                     obs_q[1].illegal_instr, obs_q[1].reg_write, obs_q[2].mem_read, obs_q[2].alu_src_b);
        end
    endtask

    task automatic test_reset_mid_store;
        model(6'h2B, 6'h00, 1'b0, 0, 2);
        drive(6'h2B, 6'h00, 1'b0, 4);
        checks++;
        if (obs_q[3].mem_write !== 1'b1) begin
            errors++;
            $display("FAIL store_reach_wr: mem_write=%b expected 1", obs_q[3].mem_write);
        end
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        if (cur !== '0) begin
            errors++;
            $display("FAIL reset_in_mem_wr: got %h expected 0", cur);
        end
        model(6'h00, 6'h22, 1'b0, 0, 0);
        drive(6'h00, 6'h22, 1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i].o) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i].o);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] ops [15] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08, 6'h09,
                                 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F, 6'h11};
        logic [5:0] fns [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01, 6'h3F};
        logic [5:0] op, fn;
        logic       z;
        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, 14)];
            fn = fns[$urandom_range(0, 16)];
            z  = 1'($urandom_range(0, 1));
            model(op, fn, z, $urandom_range(0, 3), $urandom_range(0, 3));
            drive(op, fn, z, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i].o) begin
                    errors++;
                    $display("FAIL rand%0d op=%h fn=%h cycle %0d: got %h expected %h",
                             k, op, fn, i, obs_q[i], exp_q[i].o);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero_flag = 1'b0; mem_ready = 1'b1;
        test_reset;
        test_add;
        test_lw_wait;
        test_branch;
        test_imm_ops;
        test_illegal;
        test_reset_mid_store;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
